// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready stream carrying a datapath and a control payload
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  modport master (output valid, data, ctrl, input ready);
  modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cnt_clr,
  pipe_stage_skid_if.slave       up,
  pipe_stage_skid_if.master      dn,
  output logic [1:0]             level,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, drain;
  assign up.ready = state != FULL;
  assign dn.valid = state != EMPTY;
  assign dn.data  = main_data;
  assign dn.ctrl  = main_ctrl;
  assign level    = state;
  assign accept   = up.valid & up.ready;
  assign drain    = dn.valid & dn.ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_data <= up.data;
          main_ctrl <= up.ctrl;
          state     <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            main_data <= up.data;
            main_ctrl <= up.ctrl;
          end else if (accept) begin
            skid_data <= up.data;
            skid_ctrl <= up.ctrl;
            state     <= FULL;
          end else if (drain) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end
        end
        FULL: if (drain) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          skid_ctrl <= '0;
          state     <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  // clear wins over a same-cycle increment; flush only masks the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (cnt_clr) stall_cnt <= '0;
    else if (dn.valid && !dn.ready && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized and directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = 8;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          flush = 0;
  logic          cnt_clr = 0;
  logic [1:0]    level;
  logic [SW-1:0] stall_cnt;
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn();
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .up(up.slave), .dn(dn.master), .level(level), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [DW+CW-1:0] exp_q[$];
  int m_cnt = 0;
  int n;
  logic acc, drn;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(logic v, logic [DW-1:0] d, logic [CW-1:0] c, logic r, logic f, logic cl);
    @(posedge clk);
    #1;
    up.valid = v;
    up.data  = d;
    up.ctrl  = c;
    dn.ready = r;
    flush    = f;
    cnt_clr  = cl;
  endtask
  // Reference: the stage is a FIFO of at most two entries; counter follows its stated rules
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      chk("rst_in_ready", 64'(up.ready), 1);
      chk("rst_out_valid", 64'(dn.valid), 0);
      chk("rst_level", 64'(level), 0);
      chk("rst_out_ctrl", 64'(dn.ctrl), 0);
    end else begin
      n = exp_q.size();
      chk("in_ready", 64'(up.ready), 64'(n < 2));
      chk("out_valid", 64'(dn.valid), 64'(n > 0));
      chk("level", 64'(level), 64'(n));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (n > 0) chk("out_payload", 64'({dn.data, dn.ctrl}), 64'(exp_q[0]));
      else chk("out_ctrl_idle", 64'(dn.ctrl), 0);
      acc = up.valid && n < 2;
      drn = dn.ready && n > 0;
      if (cnt_clr) m_cnt = 0;
      else if (n > 0 && !dn.ready && !flush && m_cnt < (1 << SW) - 1) m_cnt++;
      if (drn) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back({up.data, up.ctrl});
    end
  end
  initial begin
    up.valid = 0; up.data = '0; up.ctrl = '0; dn.ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) drive(1, DW'(32'h11 + i), CW'($urandom), 1, 0, 0);
    repeat (3) drive(0, $urandom, CW'($urandom), 1, 0, 0);
    drive(1, 32'h55, 16'h1234, 0, 0, 0);
    drive(1, 32'hA, 16'hBEEF, 0, 0, 0);
    repeat (3) drive(1, $urandom, CW'($urandom), 0, 0, 0);
    repeat (3) drive(0, $urandom, CW'($urandom), 1, 0, 0);
    drive(1, 32'h77, 16'h00F0, 0, 0, 0);
    drive(1, 32'h78, 16'h0F00, 0, 0, 0);
    drive(1, 32'h79, 16'hF000, 0, 1, 0);
    repeat (2) drive(0, $urandom, CW'($urandom), 1, 0, 0);
    drive(1, 32'hC0DE, 16'h00AA, 0, 0, 0);
    repeat ((1 << SW) + 5) drive(0, $urandom, CW'($urandom), 0, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'((1 << SW) - 1));
    drive(0, $urandom, CW'($urandom), 0, 0, 1);
    drive(0, $urandom, CW'($urandom), 1, 0, 0);
    drive(0, $urandom, CW'($urandom), 1, 0, 0);
    drive(1, 32'hD1, 16'h0011, 0, 0, 0);
    drive(1, 32'hD2, 16'h0022, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_in_ready", 64'(up.ready), 1);
    chk("async_out_valid", 64'(dn.valid), 0);
    chk("async_level", 64'(level), 0);
    chk("async_stall", 64'(stall_cnt), 0);
    chk("async_out_ctrl", 64'(dn.ctrl), 0);
    chk("async_out_data", 64'(dn.data), 0);
    up.valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 9) < 7, $urandom, CW'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
    repeat (4) drive(0, $urandom, CW'($urandom), 1, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
